rbi_mem_l1_req_node: RTL and testbench
======================================

Name: rbi_mem_l1_req_node

Overview:
- Ringbus requester stop on the L1 side. It is the initiator counterpart of the L2 responder cluster.
- Accepts one memory request at a time from an L1 miss port, injects it into an empty ring slot, and forwards all other ring traffic with one cycle of latency.
- Captures the response tagged for this node and hands it back to the L1 port.
- Detects lost transactions with a timeout counter.

Parameters:
- ADDR_W, 48, ring address width (`l2addr` width).
- DATA_W, 128, ring data width (`tile` width).
- OPM_LDX, JX2_RBI_OPM_LDX, ring opcode for a line load.
- OPM_STX, JX2_RBI_OPM_STX, ring opcode for a line store.
- TIMEOUT, 1023, cycles waited in WAIT_RESP before an error response; counter is 10 bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- memAddrIn  in  ADDR_W  ring address from upstream stop
- memDataIn  in  DATA_W  ring data from upstream
- memOpmIn  in  16  ring opcode from upstream; opm[7:0]==0 means empty slot
- memSeqIn  in  16  ring sequence {node[15:8], tag[7:0]}
- memAddrOut  out  ADDR_W  registered ring address to downstream
- memDataOut  out  DATA_W  registered ring data to downstream
- memOpmOut  out  16  registered ring opcode to downstream
- memSeqOut  out  16  registered ring sequence to downstream
- unitNodeId  in  8  this stop's node ID
- l1ReqValid  in  1  L1 request present
- l1ReqStore  in  1  1 = store (STX), 0 = load (LDX)
- l1ReqAddr  in  ADDR_W  request line address
- l1ReqData  in  DATA_W  store data
- l1ReqReady  out  1  node can accept a request this cycle
- l1RespValid  out  1  one-cycle response strobe
- l1RespData  out  DATA_W  load data; zero on store or error
- l1RespErr  out  1  1 = timeout error

Behaviour:
- Reset:
  - All mem*Out are 0, so the ring emits an empty slot.
  - l1RespValid=0, l1RespData=0, l1RespErr=0, l1ReqReady=0.
  - State is IDLE, tag=8'h01, timeout counter=0.
  - Reset asserted mid-transaction abandons the transaction; no response is produced.
- Ring pass-through: every cycle, mem*Out <= mem*In unless the slot is replaced by an injection or a consume. Latency is exactly one cycle.
- States:
  - IDLE: l1ReqReady=1. On l1ReqValid, latch addr, data and store flag, then go to INJECT. l1ReqReady drops in the following cycle.
  - INJECT: wait for memOpmIn[7:0]==0. In that cycle drive the output slot with:
    - opm = {8'h00, store?OPM_STX:OPM_LDX}
    - seq = {unitNodeId, tag}
    - addr = latched addr
    - data = latched data, or 0 for a load
    
    Then go to WAIT_RESP and clear the counter. An occupied incoming slot always passes through unchanged; no slot is ever dropped.
  - WAIT_RESP: a response matches when memOpmIn[7:6]==2'b01, memSeqIn[15:8]==unitNodeId and memSeqIn[7:0]==tag. On a match:
    - consume the slot: the output slot is all zero that cycle
    - latch memDataIn into l1RespData, or 0 for a store
    - go to DONE
    
    Otherwise increment the counter. When the counter reaches TIMEOUT, set l1RespErr=1, set l1RespData=0, and go to DONE.
  - DONE: l1RespValid=1 for exactly one cycle, tag advances, return to IDLE. l1RespErr/l1RespData hold until the next DONE.
- Tag sequence: 01..FF, then wraps to 01. Tag 00 is never issued, because seq[7:0]==0 marks "no transaction".
- Stale responses: a response with node==unitNodeId and tag!=current tag (late arrival after a timeout) is consumed and discarded in any state.
- Foreign traffic:
  - Responses for other nodes pass through untouched.
  - Requests (opm[7:6]!=2'b01), including ones carrying this node's ID, pass through untouched.
- Simultaneous events:
  - A matching response arriving in the same cycle as counter==TIMEOUT is treated as success; the response wins.
  - In INJECT, if the empty slot arrives in the same cycle the state is entered, injection happens that cycle.
- Only one transaction is outstanding; there are no request queues.

Test Plan:
- Ring idle (opm=0), L1 load addr=0x1000, unitNodeId=0x10:
  - one cycle after INJECT entry, memOpmOut[7:0]=OPM_LDX and memSeqOut=0x1001.
  - Feed response opm=0x0040 (opm[7:6]=2'b01), seq=0x1001, data=0xDEADBEEF… → the next cycle memOpmOut=0, and l1RespValid pulses once with that data and l1RespErr=0.
- Ring busy with foreign traffic for 5 cycles (opm=OPM_LDX, seq=0x2005), with a pending store → those 5 slots appear unchanged at the output one cycle later, and the store is injected in the first empty slot with seq=0x10xx.
- No response after injection → after TIMEOUT cycles, l1RespValid=1, l1RespErr=1, l1RespData=0. A late response with the old tag is then consumed (output slot zero), and no second strobe occurs.
- Issue 256 back-to-back requests → tags run 01..FF then 01; seq[7:0] is never 00.
- Response for node 0x20 arrives while this stop (node 0x10) is in WAIT_RESP → passed through unchanged, the counter keeps running, and there is no L1 strobe.
- Reset asserted in WAIT_RESP → next cycle the outputs are zero and l1ReqReady returns in IDLE with tag=01; the matching response arriving afterwards is consumed as stale.

Source files
------------

// File: rtl/rbi_mem_l1_req_node.sv
// Ringbus requester stop: injects one L1 request into an empty ring slot.
// It captures the tagged response, or reports a timeout, back to the L1 port.
module rbi_mem_l1_req_node #(
    parameter int          ADDR_W  = 48,
    parameter int          DATA_W  = 128,
    parameter logic [7:0]  OPM_LDX = 8'h93,
    parameter logic [7:0]  OPM_STX = 8'h97,
    parameter logic [9:0]  TIMEOUT = 10'd1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] memAddrIn,
    input  logic [DATA_W-1:0] memDataIn,
    input  logic [15:0]       memOpmIn,
    input  logic [15:0]       memSeqIn,
    output logic [ADDR_W-1:0] memAddrOut,
    output logic [DATA_W-1:0] memDataOut,
    output logic [15:0]       memOpmOut,
    output logic [15:0]       memSeqOut,
    input  logic [7:0]        unitNodeId,
    input  logic              l1ReqValid,
    input  logic              l1ReqStore,
    input  logic [ADDR_W-1:0] l1ReqAddr,
    input  logic [DATA_W-1:0] l1ReqData,
    output logic              l1ReqReady,
    output logic              l1RespValid,
    output logic [DATA_W-1:0] l1RespData,
    output logic              l1RespErr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INJECT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_tag, w_tag_nxt;
    logic [9:0]          r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_store;
    logic [DATA_W-1:0]   r_resp_data, w_resp_data_nxt;
    logic                r_resp_err, w_resp_err_nxt;
    logic [ADDR_W-1:0]   r_addr_out, w_addr_out_nxt;
    logic [DATA_W-1:0]   r_data_out, w_data_out_nxt;
    logic [15:0]         r_opm_out, w_opm_out_nxt;
    logic [15:0]         r_seq_out, w_seq_out_nxt;
    logic                w_latch;
    logic                w_mine;
    logic                w_empty;

    // Any response addressed to this node is removed from the ring:
    // either it completes the transaction or it is a stale leftover.
    assign w_mine  = (memOpmIn[7:6] == 2'b01) && (memSeqIn[15:8] == unitNodeId);
    assign w_empty = (memOpmIn[7:0] == 8'h00);

    always_comb begin
        w_state_nxt     = r_state;
        w_tag_nxt       = r_tag;
        w_cnt_nxt       = r_cnt;
        w_resp_data_nxt = r_resp_data;
        w_resp_err_nxt  = r_resp_err;
        w_latch         = 1'b0;
        w_addr_out_nxt  = memAddrIn;
        w_data_out_nxt  = memDataIn;
        w_opm_out_nxt   = memOpmIn;
        w_seq_out_nxt   = memSeqIn;

        if (w_mine) begin
            w_addr_out_nxt = '0;
            w_data_out_nxt = '0;
            w_opm_out_nxt  = '0;
            w_seq_out_nxt  = '0;
        end

        unique case (r_state)
            S_IDLE: begin
                if (l1ReqValid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_INJECT;
                end
            end
            S_INJECT: begin
                if (w_empty) begin
                    w_addr_out_nxt = r_addr;
                    w_data_out_nxt = r_store ? r_data : '0;
                    w_opm_out_nxt  = {8'h00, r_store ? OPM_STX : OPM_LDX};
                    w_seq_out_nxt  = {unitNodeId, r_tag};
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                // A matching response beats a simultaneous timeout.
                if (w_mine && (memSeqIn[7:0] == r_tag)) begin
                    w_resp_data_nxt = r_store ? '0 : memDataIn;
                    w_resp_err_nxt  = 1'b0;
                    w_state_nxt     = S_DONE;
                end else if (r_cnt == TIMEOUT) begin
                    w_resp_data_nxt = '0;
                    w_resp_err_nxt  = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            S_DONE: begin
                w_tag_nxt   = (r_tag == 8'hFF) ? 8'h01 : r_tag + 8'h01;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tag       <= 8'h01;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_store     <= 1'b0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_addr_out  <= '0;
            r_data_out  <= '0;
            r_opm_out   <= '0;
            r_seq_out   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tag       <= w_tag_nxt;
            r_cnt       <= w_cnt_nxt;
            r_resp_data <= w_resp_data_nxt;
            r_resp_err  <= w_resp_err_nxt;
            r_addr_out  <= w_addr_out_nxt;
            r_data_out  <= w_data_out_nxt;
            r_opm_out   <= w_opm_out_nxt;
            r_seq_out   <= w_seq_out_nxt;
            if (w_latch) begin
                r_addr  <= l1ReqAddr;
                r_data  <= l1ReqData;
                r_store <= l1ReqStore;
            end
        end
    end

    assign memAddrOut  = r_addr_out;
    assign memDataOut  = r_data_out;
    assign memOpmOut   = r_opm_out;
    assign memSeqOut   = r_seq_out;
    assign l1ReqReady  = (r_state == S_IDLE) && !reset;
    assign l1RespValid = (r_state == S_DONE);
    assign l1RespData  = r_resp_data;
    assign l1RespErr   = r_resp_err;

endmodule

// File: tb/tb_rbi_mem_l1_req_node.sv
// Directed bench for rbi_mem_l1_req_node: inject, pass-through,
// timeout, stale consume, tag wrap and reset abandonment.
module tb_rbi_mem_l1_req_node;

    localparam logic [7:0] LDX = 8'h93;
    localparam logic [7:0] STX = 8'h97;

    logic          clock = 1'b0;
    logic          reset;
    logic [47:0]   memAddrIn;
    logic [127:0]  memDataIn;
    logic [15:0]   memOpmIn;
    logic [15:0]   memSeqIn;
    logic [47:0]   memAddrOut;
    logic [127:0]  memDataOut;
    logic [15:0]   memOpmOut;
    logic [15:0]   memSeqOut;
    logic [7:0]    unitNodeId;
    logic          l1ReqValid;
    logic          l1ReqStore;
    logic [47:0]   l1ReqAddr;
    logic [127:0]  l1ReqData;
    logic          l1ReqReady;
    logic          l1RespValid;
    logic [127:0]  l1RespData;
    logic          l1RespErr;

    int n_vec = 0;
    int n_err = 0;

    rbi_mem_l1_req_node #(
        .ADDR_W  (48),
        .DATA_W  (128),
        .OPM_LDX (LDX),
        .OPM_STX (STX),
        .TIMEOUT (10'd1023)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .memAddrIn   (memAddrIn),
        .memDataIn   (memDataIn),
        .memOpmIn    (memOpmIn),
        .memSeqIn    (memSeqIn),
        .memAddrOut  (memAddrOut),
        .memDataOut  (memDataOut),
        .memOpmOut   (memOpmOut),
        .memSeqOut   (memSeqOut),
        .unitNodeId  (unitNodeId),
        .l1ReqValid  (l1ReqValid),
        .l1ReqStore  (l1ReqStore),
        .l1ReqAddr   (l1ReqAddr),
        .l1ReqData   (l1ReqData),
        .l1ReqReady  (l1ReqReady),
        .l1RespValid (l1RespValid),
        .l1RespData  (l1RespData),
        .l1RespErr   (l1RespErr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic ring(input logic [15:0] opm, input logic [15:0] seq,
                        input logic [47:0] addr, input logic [127:0] data);
        memOpmIn  = opm;
        memSeqIn  = seq;
        memAddrIn = addr;
        memDataIn = data;
    endtask

    task automatic ring_idle;
        ring(16'h0, 16'h0, 48'h0, 128'h0);
    endtask

    task automatic request(input logic st, input logic [47:0] a,
                           input logic [127:0] d);
        l1ReqValid = 1'b1;
        l1ReqStore = st;
        l1ReqAddr  = a;
        l1ReqData  = d;
        step();
        l1ReqValid = 1'b0;
    endtask

    initial begin
        logic [7:0]   exp_tag;
        logic [127:0] big;
        int           waited;
        logic         seen;

        big        = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        reset      = 1'b1;
        unitNodeId = 8'h10;
        l1ReqValid = 1'b0;
        l1ReqStore = 1'b0;
        l1ReqAddr  = '0;
        l1ReqData  = '0;
        ring_idle();
        step();
        step();
        chk("rst_opm", memOpmOut, 0);
        chk("rst_seq", memSeqOut, 0);
        chk("rst_data", memDataOut, 0);
        chk("rst_valid", l1RespValid, 0);
        chk("rst_ready", l1ReqReady, 0);
        chk("rst_err", l1RespErr, 0);
        reset = 1'b0;
        step();
        chk("idle_ready", l1ReqReady, 1);

        // load on an idle ring, tag 01
        request(1'b0, 48'h1000, 128'h55);
        chk("inj_ready_drop", l1ReqReady, 0);
        step();
        chk("ld_opm", memOpmOut, {8'h00, LDX});
        chk("ld_seq", memSeqOut, 16'h1001);
        chk("ld_addr", memAddrOut, 48'h1000);
        chk("ld_data", memDataOut, 0);
        ring(16'h0040, 16'h1001, 48'h1000, big);
        step();
        chk("ld_consume_opm", memOpmOut, 0);
        chk("ld_consume_seq", memSeqOut, 0);
        chk("ld_valid", l1RespValid, 1);
        chk("ld_rdata", l1RespData, big);
        chk("ld_err", l1RespErr, 0);
        ring_idle();
        step();
        chk("ld_single_strobe", l1RespValid, 0);
        chk("ld_ready_back", l1ReqReady, 1);

        // store behind five busy foreign slots, tag 02
        for (int i = 0; i < 5; i++) begin
            ring({8'h00, LDX}, 16'h2005, 48'hA0 + 48'(i), 128'(i + 7));
            if (i == 0) begin
                request(1'b1, 48'h2000, 128'hCAFE);
            end else begin
                step();
            end
            chk("fw_opm", memOpmOut, {8'h00, LDX});
            chk("fw_seq", memSeqOut, 16'h2005);
            chk("fw_addr", memAddrOut, 48'hA0 + 48'(i));
            chk("fw_data", memDataOut, 128'(i + 7));
        end
        ring_idle();
        step();
        chk("st_opm", memOpmOut, {8'h00, STX});
        chk("st_seq", memSeqOut, 16'h1002);
        chk("st_addr", memAddrOut, 48'h2000);
        chk("st_data", memDataOut, 128'hCAFE);
        ring(16'h0040, 16'h1002, 48'h0, 128'h1234);
        step();
        chk("st_valid", l1RespValid, 1);
        chk("st_rdata", l1RespData, 0);
        chk("st_err", l1RespErr, 0);
        ring_idle();
        step();

        // foreign response, then timeout, tag 03
        request(1'b0, 48'h3000, 128'h0);
        step();
        chk("to_seq", memSeqOut, 16'h1003);
        ring(16'h0040, 16'h2003, 48'h44, 128'h77);
        step();
        chk("oth_opm", memOpmOut, 16'h0040);
        chk("oth_seq", memSeqOut, 16'h2003);
        chk("oth_data", memDataOut, 128'h77);
        chk("oth_nostrobe", l1RespValid, 0);
        ring_idle();
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 1100) begin
            step();
            waited++;
            seen = l1RespValid;
        end
        chk("to_seen", seen, 1);
        chk("to_cycles", waited, 1023);
        chk("to_err", l1RespErr, 1);
        chk("to_rdata", l1RespData, 0);
        step();
        chk("to_single_strobe", l1RespValid, 0);
        ring(16'h0040, 16'h1003, 48'h3000, 128'h99);
        step();
        chk("stale_opm", memOpmOut, 0);
        chk("stale_seq", memSeqOut, 0);
        chk("stale_nostrobe", l1RespValid, 0);
        ring_idle();
        step();
        chk("stale_nostrobe2", l1RespValid, 0);
        chk("err_hold", l1RespErr, 1);

        // tags 04..FF then wrap to 01, 02
        exp_tag = 8'h04;
        for (int k = 0; k < 254; k++) begin
            request(1'b0, 48'h4000, 128'h0);
            step();
            chk("tag_seq", memSeqOut, {8'h10, exp_tag});
            ring(16'h0040, {8'h10, exp_tag}, 48'h0, 128'(k));
            step();
            chk("tag_resp", l1RespData, 128'(k));
            ring_idle();
            step();
            exp_tag = (exp_tag == 8'hFF) ? 8'h01 : exp_tag + 8'h01;
        end
        chk("tag_after_wrap", exp_tag, 8'h03);

        // reset while waiting, tag 03 outstanding
        request(1'b0, 48'h5000, 128'h0);
        step();
        chk("rw_seq", memSeqOut, 16'h1003);
        reset = 1'b1;
        step();
        chk("rw_opm", memOpmOut, 0);
        chk("rw_ready", l1ReqReady, 0);
        reset = 1'b0;
        #1;
        chk("rw_ready_back", l1ReqReady, 1);
        ring(16'h0040, 16'h1003, 48'h5000, 128'hABC);
        step();
        chk("rw_stale_opm", memOpmOut, 0);
        chk("rw_nostrobe", l1RespValid, 0);
        ring_idle();
        request(1'b0, 48'h6000, 128'h0);
        step();
        chk("rw_tag01", memSeqOut, 16'h1001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
